// File: rtl/pc_gen_pipe.sv
// Fetch PC generator: BOOT/RUN/PEND sequencer with stall-time redirect/trap latching.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned redirects into traps with a misalign_err pulse.
module pc_gen_pipe #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'hBFC0_0180,
    parameter int unsigned     STEP         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect_pending,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] STEP_W     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t          state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] pend_tgt_r, pend_tgt_s;
    logic            pend_trap_r, pend_trap_s;
    logic            pc_valid_r, redirect_pending_r;
    logic            mis_r, mis_s;
    logic [XLEN-1:0] redir_tgt_s;
    logic            redir_bad_s;
    logic            take_trap_s;

`ifdef PC_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

    // Misaligned redirects are promoted to traps; aligned ones pass through untouched.
    always_comb begin
        redir_tgt_s = redirect_target;
        redir_bad_s = redirect_valid & misaligned(redirect_target);
    end
`else
    function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

    // Without the check, the low address bits are simply dropped.
    always_comb begin
        redir_tgt_s = align_down(redirect_target);
        redir_bad_s = 1'b0;
    end
`endif

    assign take_trap_s = trap_valid | redir_bad_s;

    // Next-state, next-pc and pending-slot selection.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        pend_tgt_s  = pend_tgt_r;
        pend_trap_s = pend_trap_r;
        mis_s       = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_s = ST_RUN;
                pc_s    = RESET_VECTOR;
            end
            ST_RUN: begin
                mis_s = redir_bad_s & ~trap_valid;
                if (en) begin
                    if (take_trap_s) begin
                        pc_s = TRAP_VECTOR;
                    end else if (redirect_valid) begin
                        pc_s = redir_tgt_s;
                    end else begin
                        pc_s = pc_r + STEP_W;
                    end
                end else begin
                    if (take_trap_s) begin
                        state_s     = ST_PEND;
                        pend_trap_s = 1'b1;
                        pend_tgt_s  = TRAP_VECTOR;
                    end else if (redirect_valid) begin
                        state_s     = ST_PEND;
                        pend_trap_s = 1'b0;
                        pend_tgt_s  = redir_tgt_s;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_PEND: begin
                // A pending trap cannot be displaced, so a redirect seen now is not accepted.
                mis_s = redir_bad_s & ~trap_valid & ~pend_trap_r;
                if (en) begin
                    state_s     = ST_RUN;
                    pend_trap_s = 1'b0;
                    pend_tgt_s  = {XLEN{1'b0}};
                    if (take_trap_s) begin
                        pc_s = TRAP_VECTOR;
                    end else if (redirect_valid & ~pend_trap_r) begin
                        pc_s = redir_tgt_s;
                    end else begin
                        pc_s = pend_tgt_r;
                    end
                end else begin
                    if (take_trap_s) begin
                        pend_trap_s = 1'b1;
                        pend_tgt_s  = TRAP_VECTOR;
                    end else if (redirect_valid & ~pend_trap_r) begin
                        pend_tgt_s = redir_tgt_s;
                    end else begin
                        pend_tgt_s = pend_tgt_r;
                    end
                end
            end
            default: begin
                state_s     = ST_BOOT;
                pc_s        = RESET_VECTOR;
                pend_trap_s = 1'b0;
                pend_tgt_s  = {XLEN{1'b0}};
            end
        endcase
    end

    // State, pc, pending slot and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= ST_BOOT;
            pc_r               <= RESET_VECTOR;
            pend_tgt_r         <= {XLEN{1'b0}};
            pend_trap_r        <= 1'b0;
            pc_valid_r         <= 1'b0;
            redirect_pending_r <= 1'b0;
            mis_r              <= 1'b0;
        end else begin
            state_r            <= state_s;
            pc_r               <= pc_s;
            pend_tgt_r         <= pend_tgt_s;
            pend_trap_r        <= pend_trap_s;
            pc_valid_r         <= (state_s != ST_BOOT);
            redirect_pending_r <= (state_s == ST_PEND);
            mis_r              <= mis_s;
        end
    end

    assign pc               = pc_r;
    assign pc_valid         = pc_valid_r;
    assign redirect_pending = redirect_pending_r;
    assign misalign_err     = mis_r;

endmodule

// File: tb/tb_pc_gen_pipe.sv
// Scoreboard bench for pc_gen_pipe: a behavioural fetch model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_pc_gen_pipe;

    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] TV   = 32'hBFC0_0180;
    localparam int          STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap_valid = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        redirect_pending;
    logic        misalign_err;

    pc_gen_pipe dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .pc(pc), .pc_valid(pc_valid),
        .redirect_pending(redirect_pending), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        p;
        logic        m;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model: pending is 0 = none, 1 = redirect, 2 = trap.
    bit          m_boot = 1'b1;
    logic [31:0] m_pc = RV;
    int          m_pend = 0;
    logic [31:0] m_pend_addr = 32'h0;
    logic        m_mis = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          bad;
        int          req;
        `ifdef PC_ALIGN_CHECK_EN
        bad = redirect_valid && ((redirect_target % STEP) != 0);
        tgt = redirect_target;
        `else
        bad = 1'b0;
        tgt = redirect_target - (redirect_target % STEP);
        `endif
        m_mis = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = RV;
        end else begin
            req   = (trap_valid || bad) ? 2 : (redirect_valid ? 1 : 0);
            m_mis = redirect_valid && bad && !trap_valid && (m_pend != 2);
            if (en) begin
                if (req == 2 || m_pend == 2) m_pc = TV;
                else if (req == 1)           m_pc = tgt;
                else if (m_pend == 1)        m_pc = m_pend_addr;
                else                         m_pc = m_pc + STEP;
                m_pend = 0;
            end else if (req == 2) begin
                m_pend = 2;
            end else if (req == 1 && m_pend != 2) begin
                m_pend      = 1;
                m_pend_addr = tgt;
            end
        end
    endtask

    task automatic step(input bit e, input bit rv, input logic [31:0] rt, input bit tv);
        exp_t x;
        en = e; redirect_valid = rv; redirect_target = rt; trap_valid = tv;
        model_step();
        @(posedge clk);
        x.pc = m_pc; x.v = !m_boot; x.p = (m_pend != 0); x.m = m_mis;
        sb_q.push_back(x);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        en = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0; redirect_target = 32'h0;
        #1;
        cmp("rst_pc", pc, RV);
        cmp("rst_valid", {31'b0, pc_valid}, 32'h0);
        cmp("rst_pending", {31'b0, redirect_pending}, 32'h0);
        cmp("rst_mis", {31'b0, misalign_err}, 32'h0);
        m_boot = 1'b1; m_pc = RV; m_pend = 0; m_mis = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cmp("boot_pc", pc, RV);
        cmp("boot_valid", {31'b0, pc_valid}, 32'h0);
    endtask

    // Monitor: pop one expected record per cycle and compare every output.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp("sb_pc", pc, e.pc);
            cmp("sb_valid", {31'b0, pc_valid}, {31'b0, e.v});
            cmp("sb_pending", {31'b0, redirect_pending}, {31'b0, e.p});
            cmp("sb_mis", {31'b0, misalign_err}, {31'b0, e.m});
        end
    end

    initial begin
        logic [31:0] rt;
        do_reset();

        // Boot then sequential fetch
        step(1'b1, 1'b0, 32'h0, 1'b0);
        cmp("seq0", pc, 32'hBFC0_0000);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        cmp("seq1", pc, 32'hBFC0_0004);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        cmp("seq2", pc, 32'hBFC0_0008);

        // Redirect latched during stall
        step(1'b0, 1'b1, 32'h0000_1000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        cmp("stall_pc", pc, 32'hBFC0_0008);
        cmp("stall_pending", {31'b0, redirect_pending}, 32'h1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        cmp("pend_release_pc", pc, 32'h0000_1000);
        cmp("pend_release_flag", {31'b0, redirect_pending}, 32'h0);

        // Trap beats same-cycle redirect
        step(1'b1, 1'b1, 32'h0000_2000, 1'b1);
        cmp("trap_prio", pc, 32'hBFC0_0180);

        // Pending trap beats later redirect
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_3000, 1'b0);
        cmp("pend_trap", pc, 32'hBFC0_0180);

        // Wrap at top of address space
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cmp("wrap_top", pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        cmp("wrap_zero", pc, 32'h0000_0000);

        // Misaligned redirect
        step(1'b1, 1'b1, 32'h0000_1002, 1'b0);
        `ifdef PC_ALIGN_CHECK_EN
        cmp("mis_pc", pc, 32'hBFC0_0180);
        cmp("mis_flag", {31'b0, misalign_err}, 32'h1);
        `else
        cmp("mis_pc", pc, 32'h0000_1000);
        cmp("mis_flag", {31'b0, misalign_err}, 32'h0);
        `endif

        // Reset while a redirect is pending discards it
        step(1'b0, 1'b1, 32'h0000_4000, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        cmp("post_reset_pc", pc, 32'hBFC0_0004);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0:       rt = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                1:       rt = $urandom;
                default: rt = $urandom & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, rt,
                     $urandom_range(0, 9) == 0);
            end
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        cmp("drain", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
